// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_pkg
// Purpose : Shared definitions for the writeback skid stage: default payload
//           widths, writeback-control bit positions and the occupancy-state
//           encoding used by pipe_skid_stage.
// Ports   : none (package)
// Config  : PIPE_SKID_STAGE_PERF_EN (consumed by pipe_skid_stage)
// Revision: 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // Default widths of the writeback payload.
  localparam int DATA_W_DEF = 32;
  localparam int CTRL_W_DEF = 2;
  localparam int REG_W_DEF  = 5;

  // Positions inside the writeback-control field.
  localparam int WB_REGWRITE_BIT = 1;
  localparam int WB_MEMTOREG_BIT = 0;

  // Occupancy encoding; the code equals the number of held entries.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_e;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_entry_reg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_entry_reg
// Purpose : One payload slot of the skid stage. Loads d when load is high,
//           clears to zero on reset or on clr (clr wins over load).
// Ports   : clk   - clock, rising edge
//           rst_n - synchronous active-low reset
//           clr   - synchronous clear
//           load  - load enable
//           d     - next payload
//           q     - held payload
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule : pipe_entry_reg
`default_nettype wire

// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module  : pipe_skid_stage
// Purpose : Two-entry writeback pipeline stage (head + skid register) with a
//           registered in_ready_o, so upstream ready never depends
//           combinationally on out_ready_i. Entries leave in acceptance order.
// Ports   : clk_i, rst_n_i         - clock, synchronous active-low reset
//           flush_i                - discard all held entries
//           in_valid_i/in_ready_o  - upstream handshake
//           in_wb_i/in_rdata_i/in_alu_i/in_rd_i - upstream payload
//           out_valid_o/out_ready_i - downstream handshake
//           out_wb_o/out_rdata_o/out_alu_o/out_rd_o - head payload
//           count_o                - occupancy 0..2
//           stall_cnt_o            - stall counter (PIPE_SKID_STAGE_PERF_EN only)
// Config  : PIPE_SKID_STAGE_PERF_EN adds the 32-bit stall counter output.
// Revision: 1.0 - initial release
// ============================================================================
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_wb_i,
  input  logic [DATA_W-1:0] in_rdata_i,
  input  logic [DATA_W-1:0] in_alu_i,
  input  logic [REG_W-1:0]  in_rd_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_wb_o,
  output logic [DATA_W-1:0] out_rdata_o,
  output logic [DATA_W-1:0] out_alu_o,
  output logic [REG_W-1:0]  out_rd_o,
  output logic [1:0]        count_o
`ifdef PIPE_SKID_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt_o
`endif
);

  localparam int ENTRY_W = CTRL_W + 2 * DATA_W + REG_W;

  occ_state_e          r_state;
  occ_state_e          w_state_nxt;
  logic                r_in_ready;

  logic                w_accept;
  logic                w_pop;
  logic                w_head_load;
  logic                w_head_from_skid;
  logic                w_skid_load;

  logic [CTRL_W-1:0]   w_in_wb;
  logic [ENTRY_W-1:0]  w_in_entry;
  logic [ENTRY_W-1:0]  w_head_d;
  logic [ENTRY_W-1:0]  w_head_q;
  logic [ENTRY_W-1:0]  w_skid_q;

  logic [CTRL_W-1:0]   w_head_wb;

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  assign in_ready_o  = r_in_ready;
  assign out_valid_o = (r_state != OCC_EMPTY);
  assign w_accept    = in_valid_i && r_in_ready;
  assign w_pop       = out_valid_o && out_ready_i;
  assign count_o     = r_state;

  // A write to register 0 is meaningless, so RegWrite is dropped on entry.
  always_comb begin
    w_in_wb = in_wb_i;
    if (in_rd_i == '0) begin
      w_in_wb[WB_REGWRITE_BIT] = 1'b0;
    end
  end

  assign w_in_entry = {w_in_wb, in_rdata_i, in_alu_i, in_rd_i};
  assign w_head_d   = w_head_from_skid ? w_skid_q : w_in_entry;

  // --------------------------------------------------------------------------
  // Occupancy state machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state    <= OCC_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      // Ready is precomputed from the next state so it can be a flop output.
      r_in_ready <= (w_state_nxt != OCC_FULL);
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_head_load      = 1'b0;
    w_head_from_skid = 1'b0;
    w_skid_load      = 1'b0;

    case (r_state)
      OCC_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = OCC_ONE;
          w_head_load = 1'b1;
        end
      end
      OCC_ONE: begin
        if (w_accept && w_pop) begin
          w_head_load = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = OCC_FULL;
          w_skid_load = 1'b1;
        end else if (w_pop) begin
          w_state_nxt = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        // No accept is possible here: in_ready_o is low while FULL.
        if (w_pop) begin
          w_state_nxt      = OCC_ONE;
          w_head_load      = 1'b1;
          w_head_from_skid = 1'b1;
        end
      end
      default: begin
        w_state_nxt = OCC_EMPTY;
      end
    endcase

    // Flush drops everything, including a same-cycle incoming entry; the head
    // payload is left untouched so the outputs just hold while invalid.
    if (flush_i) begin
      w_state_nxt      = OCC_EMPTY;
      w_head_load      = 1'b0;
      w_head_from_skid = 1'b0;
      w_skid_load      = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Payload storage
  // --------------------------------------------------------------------------
  pipe_entry_reg #(
    .WIDTH (ENTRY_W)
  ) u_head_reg (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .clr   (1'b0),
    .load  (w_head_load),
    .d     (w_head_d),
    .q     (w_head_q)
  );

  pipe_entry_reg #(
    .WIDTH (ENTRY_W)
  ) u_skid_reg (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .clr   (flush_i),
    .load  (w_skid_load),
    .d     (w_in_entry),
    .q     (w_skid_q)
  );

  assign {w_head_wb, out_rdata_o, out_alu_o, out_rd_o} = w_head_q;

  // An invalid head must not cause a register write downstream.
  assign out_wb_o = out_valid_o ? w_head_wb : '0;

  // --------------------------------------------------------------------------
  // Optional stall counter (not affected by flush)
  // --------------------------------------------------------------------------
`ifdef PIPE_SKID_STAGE_PERF_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_stall_cnt <= '0;
    end else if (out_valid_o && !out_ready_i) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule : pipe_skid_stage
`default_nettype wire
